// File: rtl/uart_pkg.sv
// Shared constants, frame-timing helpers and FSM state type for the UART transmit feeder.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } state_t;

  function automatic int calc_bps_cnt(input int sys_clk_fre, input int bps);
    return sys_clk_fre / bps;
  endfunction

  // One frame is start + 8 data + stop bits, plus idle margin for the transmitter to settle.
  function automatic int calc_frame_cyc(input int sys_clk_fre, input int bps, input int margin);
    return 10 * calc_bps_cnt(sys_clk_fre, bps) + margin;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with registered level, full and empty flags.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [AW:0]       level_next;

  // Acceptance looks only at the registered flags, so a pop in the same cycle never frees a slot early.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_wr && !do_rd) begin
      level_next = level + 1'b1;
    end else if (!do_wr && do_rd) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
      full  <= (level_next == FULL_LVL);
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter that has no busy/ready handshake.
// Optional sticky overflow flag with ovf_clr when UART_TX_FEEDER_OVF_EN is defined.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FRE  = 50_000_000,
  parameter int BPS          = 115200,
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int EN_HI        = 4,
  parameter int FRAME_MARGIN = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
`ifdef UART_TX_FEEDER_OVF_EN
  input  logic              ovf_clr,
  output logic              ovf,
`endif
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              busy,
  output logic [BYTE_W-1:0] uart_data,
  output logic              uart_tx_en
);

  localparam int          FRAME_CYC  = calc_frame_cyc(SYS_CLK_FRE, BPS, FRAME_MARGIN);
  localparam logic [15:0] EN_LAST    = 16'(EN_HI - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYC - 1);

  state_t            state;
  state_t            state_d;
  logic [15:0]       timer;
  logic [15:0]       timer_d;
  logic              tx_en_d;
  logic [BYTE_W-1:0] data_d;
  logic              pop;
  logic [BYTE_W-1:0] head;

  sync_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // The timer counts through the whole frame from the launch edge, so the next launch lands FRAME_CYC+1 later.
  always_comb begin
    state_d = state;
    timer_d = timer;
    tx_en_d = uart_tx_en;
    data_d  = uart_data;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          tx_en_d = 1'b1;
          timer_d = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = timer + 16'd1;
        if (timer == EN_LAST) begin
          tx_en_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer + 16'd1;
        if (timer == FRAME_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      uart_tx_en <= 1'b0;
      uart_data  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      uart_tx_en <= tx_en_d;
      uart_data  <= data_d;
      busy       <= (state_d != IDLE);
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  // A dropped write takes priority over a clear landing in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: randomized writes against a queue-and-timestamp reference model.
module tb_uart_tx_feeder;

  localparam int CLK_FRE = 5_000_000;
  localparam int BAUD    = 115200;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int EN_HI   = 4;
  localparam int MARGIN  = 8;
  localparam int FRAME   = 10 * (CLK_FRE / BAUD) + MARGIN;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          wr_en     = 1'b0;
  logic [7:0]    wr_data   = 8'h00;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          busy;
  logic [7:0]    uart_data;
  logic          uart_tx_en;
`ifdef UART_TX_FEEDER_OVF_EN
  logic          ovf_clr   = 1'b0;
  logic          ovf;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: a byte queue, the edge of the last launch, and the earliest edge the next launch may use.
  logic [7:0] mq[$];
  logic [7:0] m_data    = 8'h00;
  longint     m_edge    = 0;
  longint     m_launch  = -1;
  longint     m_next_ok = 0;
  logic       m_ovf     = 1'b0;
  bit         m_acc;
  bit         m_pop;

  longint     ln_cyc[$];
  logic [7:0] ln_data[$];
  logic       prev_en = 1'b0;

  uart_tx_feeder #(
    .SYS_CLK_FRE (CLK_FRE),
    .BPS         (BAUD),
    .DEPTH       (DEPTH),
    .AW          (AW),
    .EN_HI       (EN_HI),
    .FRAME_MARGIN(MARGIN)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
`ifdef UART_TX_FEEDER_OVF_EN
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
`endif
    .full      (full),
    .empty     (empty),
    .level     (level),
    .busy      (busy),
    .uart_data (uart_data),
    .uart_tx_en(uart_tx_en)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mq.delete();
      m_data    = 8'h00;
      m_launch  = -1;
      m_next_ok = 0;
      m_ovf     = 1'b0;
    end else begin
      m_edge++;
      m_acc = wr_en && (mq.size() != DEPTH);
      m_pop = (m_edge >= m_next_ok) && (mq.size() != 0);
`ifdef UART_TX_FEEDER_OVF_EN
      if (wr_en && mq.size() == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
`endif
      if (m_pop) begin
        m_data    = mq.pop_front();
        m_launch  = m_edge;
        m_next_ok = m_edge + FRAME + 1;
      end
      if (m_acc) mq.push_back(wr_data);
    end
  end

  always @(negedge sys_clk) begin
    if (uart_tx_en && !prev_en) begin
      ln_cyc.push_back(m_edge);
      ln_data.push_back(uart_data);
    end
    prev_en = uart_tx_en;
  end

  function automatic logic [17:0] exp_vec();
    logic b, e, o;
    e = (m_launch >= 0) && (m_edge - m_launch < EN_HI);
    b = (m_launch >= 0) && (m_edge - m_launch < FRAME);
    o = m_ovf;
    return {mq.size() == DEPTH, mq.size() == 0, 5'(mq.size()), b, e, m_data, o};
  endfunction

  function automatic logic [17:0] dut_vec();
`ifdef UART_TX_FEEDER_OVF_EN
    return {full, empty, level, busy, uart_tx_en, uart_data, ovf};
`else
    return {full, empty, level, busy, uart_tx_en, uart_data, 1'b0};
`endif
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    wr_en     = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (dut_vec() !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values got=%h want=%h", dut_vec(), {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0});
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single();
    longint w_edge = 0;
    int en_cnt = 0, busy_cnt = 0;
    ln_cyc.delete(); ln_data.delete();
    for (int c = 0; c < FRAME + 30; c++) begin
      @(negedge sys_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL single cyc=%0d got=%h want=%h", m_edge, dut_vec(), exp_vec());
      end
      en_cnt += int'(uart_tx_en);
      busy_cnt += int'(busy);
      wr_en = 1'b0;
      if (c == 9) begin
        wr_en = 1'b1; wr_data = 8'h55; w_edge = m_edge + 1;
      end
    end
    checks++;
    if (ln_cyc.size() != 1) begin
      errors++;
      $display("[TB] FAIL single_count got=%0d want=1", ln_cyc.size());
    end else begin
      checks++;
      if (ln_data[0] !== 8'h55 || ln_cyc[0] != w_edge + 1) begin
        errors++;
        $display("[TB] FAIL single_launch got=%h@%0d want=55@%0d", ln_data[0], ln_cyc[0], w_edge + 1);
      end
    end
    checks++;
    if (en_cnt != EN_HI || busy_cnt != FRAME) begin
      errors++;
      $display("[TB] FAIL single_widths got en=%0d busy=%0d want en=%0d busy=%0d", en_cnt, busy_cnt, EN_HI, FRAME);
    end
  endtask

  task automatic test_back_to_back();
    ln_cyc.delete(); ln_data.delete();
    for (int c = 0; c < 3 * (FRAME + 1) + 30; c++) begin
      @(negedge sys_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL b2b cyc=%0d got=%h want=%h", m_edge, dut_vec(), exp_vec());
      end
      wr_en = (c < 3);
      wr_data = 8'h41 + 8'(c);
    end
    checks++;
    if (ln_cyc.size() != 3) begin
      errors++;
      $display("[TB] FAIL b2b_count got=%0d want=3", ln_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ln_data[i] !== 8'h41 + 8'(i)) begin
          errors++;
          $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", i, ln_data[i], 8'h41 + 8'(i));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (ln_cyc[i] - ln_cyc[i-1] != FRAME + 1) begin
          errors++;
          $display("[TB] FAIL b2b_spacing[%0d] got=%0d want=%0d", i, ln_cyc[i] - ln_cyc[i-1], FRAME + 1);
        end
      end
    end
  endtask

  task automatic test_overflow();
    ln_cyc.delete(); ln_data.delete();
    for (int c = 0; c < 17 * (FRAME + 1) + 60; c++) begin
      @(negedge sys_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL overflow cyc=%0d got=%h want=%h", m_edge, dut_vec(), exp_vec());
      end
      if (c == 27) begin
        checks++;
        if (full !== 1'b1 || level !== 5'd16) begin
          errors++;
          $display("[TB] FAIL overflow_full got full=%b level=%0d want full=1 level=16", full, level);
        end
`ifdef UART_TX_FEEDER_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
          errors++;
          $display("[TB] FAIL overflow_ovf got=%b want=1", ovf);
        end
`endif
      end
      wr_en = 1'b0;
      if (c == 0) begin
        wr_en = 1'b1; wr_data = 8'hAA;
      end else if (c >= 10 && c < 27) begin
        wr_en = 1'b1; wr_data = 8'(c - 10);
      end
    end
    checks++;
    if (ln_cyc.size() != 17) begin
      errors++;
      $display("[TB] FAIL overflow_count got=%0d want=17", ln_cyc.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (ln_data[i+1] !== 8'(i)) begin
          errors++;
          $display("[TB] FAIL overflow_data[%0d] got=%h want=%h", i, ln_data[i+1], 8'(i));
        end
      end
    end
  endtask

  task automatic test_full_pop();
    longint target = -1;
    bit hit = 1'b0;
    ln_cyc.delete(); ln_data.delete();
    for (int c = 0; c < 18 * (FRAME + 1); c++) begin
      @(negedge sys_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL full_pop cyc=%0d got=%h want=%h", m_edge, dut_vec(), exp_vec());
      end
      if (target >= 0 && m_edge + 1 == target) begin
        checks++;
        if (level !== 5'd16 || full !== 1'b1) begin
          errors++;
          $display("[TB] FAIL full_pop_before got level=%0d full=%b want 16/1", level, full);
        end
      end
      if (target >= 0 && m_edge == target) begin
        hit = 1'b1;
        checks++;
        if (level !== 5'd15 || full !== 1'b0) begin
          errors++;
          $display("[TB] FAIL full_pop_after got level=%0d full=%b want 15/0", level, full);
        end
      end
      if (target < 0 && ln_cyc.size() > 0) target = ln_cyc[0] + FRAME + 1;
      wr_en = 1'b0;
      if (c == 0) begin
        wr_en = 1'b1; wr_data = 8'h99;
      end else if (c >= 10 && c < 26) begin
        wr_en = 1'b1; wr_data = 8'($urandom);
      end else if (target >= 0 && m_edge + 1 == target) begin
        wr_en = 1'b1; wr_data = 8'hEE;
      end else if (target >= 0 && m_edge > target && $urandom_range(0, 199) == 0) begin
        wr_en = 1'b1; wr_data = 8'($urandom);
      end
    end
    wr_en = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL full_pop_reached got=0 want=1");
    end
  endtask

  task automatic test_reset_midframe();
    bit seen = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      wr_en = 1'b1; wr_data = 8'h10 + 8'(c);
    end
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge sys_clk);
      wr_en = 1'b0;
      if (uart_tx_en) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL midreset_launch got=0 want=1");
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({uart_tx_en, level, empty, busy, full, uart_data} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL midreset_values got en=%b level=%0d empty=%b busy=%b want 0/0/1/0", uart_tx_en, level, empty, busy);
    end
    @(negedge sys_clk) sys_rst_n = 1'b1;
    ln_cyc.delete(); ln_data.delete();
    for (int c = 0; c < FRAME + 50; c++) begin
      @(negedge sys_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL midreset cyc=%0d got=%h want=%h", m_edge, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (ln_cyc.size() != 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_launch got=%0d want=0", ln_cyc.size());
    end
  endtask

`ifdef UART_TX_FEEDER_OVF_EN
  task automatic test_ovf();
    @(negedge sys_clk) sys_rst_n = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge sys_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL ovf cyc=%0d got=%h want=%h", m_edge, dut_vec(), exp_vec());
      end
      if (c == 27 || c == 29 || c == 30) begin
        checks++;
        if (ovf !== (c != 29)) begin
          errors++;
          $display("[TB] FAIL ovf_step%0d got=%b want=%b", c, ovf, c != 29);
        end
      end
      wr_en = 1'b0; ovf_clr = 1'b0;
      if (c == 0) begin
        wr_en = 1'b1; wr_data = 8'h77;
      end else if (c >= 10 && c < 27) begin
        wr_en = 1'b1; wr_data = 8'(c);
      end else if (c == 28) begin
        ovf_clr = 1'b1;
      end else if (c == 29) begin
        wr_en = 1'b1; wr_data = 8'hFF; ovf_clr = 1'b1;
      end
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
`ifdef UART_TX_FEEDER_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
